// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg : shared select constants and helpers for the operand-forwarding mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fwd_pkg;

  localparam logic [1:0] FWD_SEL_A = 2'b00;
  localparam logic [1:0] FWD_SEL_B = 2'b10;
  localparam logic [1:0] FWD_SEL_C = 2'b01;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_sel_decode.sv
// ---------------------------------------------------------------------------
// fwd_sel_decode : source select to one-hot plus illegal flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_sel_decode
  import fwd_pkg::*;
#(
  parameter int NUM_IN     = 3,
  parameter int LEGACY_ENC = 1,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_IN-1:0] onehot,
  output logic              illegal
);

  generate
    if (LEGACY_ENC != 0) begin : g_legacy
      // Legacy encoding only defines three sources; 2'b11 maps to nothing.
      always_comb begin
        onehot = '0;
        case (sel)
          FWD_SEL_A: onehot[0] = 1'b1;
          FWD_SEL_B: onehot[1] = 1'b1;
          FWD_SEL_C: onehot[2] = 1'b1;
          default:   onehot    = '0;
        endcase
      end
    end else begin : g_binary
      for (genvar k = 0; k < NUM_IN; k++) begin : g_bit
        assign onehot[k] = (sel == SEL_W'(k));
      end
    end
  endgenerate

  assign illegal = ~|onehot;

endmodule

`default_nettype wire

// File: rtl/fwd_mux_pipe.sv
// ---------------------------------------------------------------------------
// fwd_mux_pipe : N-way forwarding mux with registered, flow-controlled output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_mux_pipe
  import fwd_pkg::*;
#(
  parameter int BUS_SIZE   = 10,
  parameter int NUM_IN     = 3,
  parameter int LEGACY_ENC = 1,
  parameter int ERR_CNT_W  = 8,
  localparam int SEL_W     = (LEGACY_ENC != 0) ? 2 :
                             ((clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN))
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN*BUS_SIZE-1:0] in_bus,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [BUS_SIZE-1:0]        out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sel_err,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  logic [NUM_IN-1:0]    w_onehot;
  logic [NUM_IN-1:0]    w_src;
  logic                 w_illegal;
  logic                 w_accept;
  logic [BUS_SIZE-1:0]  w_mux;

  logic [BUS_SIZE-1:0]  r_data;
  logic                 r_valid;
  logic                 r_sel_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  fwd_sel_decode #(
    .NUM_IN     (NUM_IN),
    .LEGACY_ENC (LEGACY_ENC),
    .SEL_W      (SEL_W)
  ) u_decode (
    .sel     (sel),
    .onehot  (w_onehot),
    .illegal (w_illegal)
  );

  // An illegal select falls back to input 0.
  assign w_src = w_illegal ? NUM_IN'(1) : w_onehot;

  always_comb begin
    w_mux = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_src[k]) w_mux = w_mux | in_bus[k*BUS_SIZE +: BUS_SIZE];
    end
  end

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_mux;
      r_valid <= 1'b1;
      if (w_illegal) begin
        r_sel_err <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign sel_err   = r_sel_err;
  assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fwd_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_fwd_mux_pipe : directed checks for legacy (N=3) and binary (N=5) configs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fwd_mux_pipe;

  logic        clk;
  logic        reset;

  // legacy instance
  logic [29:0] in_bus_l;
  logic [1:0]  sel_l;
  logic        in_valid_l, in_ready_l, flush_l, out_valid_l, out_ready_l, sel_err_l;
  logic [9:0]  out_data_l;
  logic [7:0]  err_cnt_l;

  // binary instance
  logic [49:0] in_bus_b;
  logic [2:0]  sel_b;
  logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, sel_err_b;
  logic [9:0]  out_data_b;
  logic [7:0]  err_cnt_b;

  int n_vec;
  int n_err;

  fwd_mux_pipe #(
    .BUS_SIZE(10), .NUM_IN(3), .LEGACY_ENC(1), .ERR_CNT_W(8)
  ) u_dut (
    .clk(clk), .reset(reset), .in_bus(in_bus_l), .sel(sel_l),
    .in_valid(in_valid_l), .in_ready(in_ready_l), .flush(flush_l),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
    .sel_err(sel_err_l), .err_cnt(err_cnt_l)
  );

  fwd_mux_pipe #(
    .BUS_SIZE(10), .NUM_IN(5), .LEGACY_ENC(0), .ERR_CNT_W(8)
  ) u_dut_bin (
    .clk(clk), .reset(reset), .in_bus(in_bus_b), .sel(sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sel_err(sel_err_b), .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    in_bus_l = {10'h003, 10'h002, 10'h001};
    in_bus_b = {10'h015, 10'h014, 10'h013, 10'h012, 10'h011};
    sel_l = 2'b00; in_valid_l = 1'b0; flush_l = 1'b0; out_ready_l = 1'b1;
    sel_b = 3'd0;  in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;

    #3;
    chk("rst_valid", {31'd0, out_valid_l}, 32'd0);
    chk("rst_data", {22'd0, out_data_l}, 32'd0);
    chk("rst_err", {31'd0, sel_err_l}, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt_l}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("idle_ready", {31'd0, in_ready_l}, 32'd1);

    // back-to-back legal selects
    in_valid_l = 1'b1; sel_l = 2'b00;
    step();
    chk("sel00_data", {22'd0, out_data_l}, 32'h001);
    chk("sel00_valid", {31'd0, out_valid_l}, 32'd1);
    sel_l = 2'b10;
    step();
    chk("sel10_data", {22'd0, out_data_l}, 32'h002);
    chk("sel10_valid", {31'd0, out_valid_l}, 32'd1);
    sel_l = 2'b01;
    step();
    chk("sel01_data", {22'd0, out_data_l}, 32'h003);
    in_valid_l = 1'b0;
    step();
    chk("drain_valid", {31'd0, out_valid_l}, 32'd0);
    chk("drain_hold", {22'd0, out_data_l}, 32'h003);

    // single illegal select
    in_valid_l = 1'b1; sel_l = 2'b11;
    step();
    chk("ill_data", {22'd0, out_data_l}, 32'h001);
    chk("ill_err", {31'd0, sel_err_l}, 32'd1);
    chk("ill_cnt", {24'd0, err_cnt_l}, 32'd1);

    // stall with downstream blocked
    sel_l = 2'b10;
    step();
    chk("stall_first", {22'd0, out_data_l}, 32'h002);
    out_ready_l = 1'b0; sel_l = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready", {31'd0, in_ready_l}, 32'd0);
      step();
      chk("stall_data", {22'd0, out_data_l}, 32'h002);
      chk("stall_valid", {31'd0, out_valid_l}, 32'd1);
    end
    out_ready_l = 1'b1;
    #1;
    chk("release_ready", {31'd0, in_ready_l}, 32'd1);
    step();
    chk("release_data", {22'd0, out_data_l}, 32'h003);
    chk("release_valid", {31'd0, out_valid_l}, 32'd1);

    // flush concurrent with an illegal accept
    sel_l = 2'b11; flush_l = 1'b1;
    step();
    flush_l = 1'b0; in_valid_l = 1'b0;
    chk("flush_valid", {31'd0, out_valid_l}, 32'd0);
    chk("flush_cnt", {24'd0, err_cnt_l}, 32'd1);
    chk("flush_err", {31'd0, sel_err_l}, 32'd1);

    // saturation of the error counter
    in_valid_l = 1'b1; sel_l = 2'b11;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 99) chk("cnt_mid", {24'd0, err_cnt_l}, 32'd101);
      if (i == 253) chk("cnt_254", {24'd0, err_cnt_l}, 32'd255);
    end
    chk("cnt_sat", {24'd0, err_cnt_l}, 32'd255);
    chk("sat_data", {22'd0, out_data_l}, 32'h001);
    in_valid_l = 1'b0;
    step();

    // binary encoding, five inputs
    in_valid_b = 1'b1; sel_b = 3'd4;
    step();
    chk("bin4_data", {22'd0, out_data_b}, 32'h015);
    chk("bin4_err", {31'd0, sel_err_b}, 32'd0);
    sel_b = 3'd6;
    step();
    chk("bin6_data", {22'd0, out_data_b}, 32'h011);
    chk("bin6_err", {31'd0, sel_err_b}, 32'd1);
    chk("bin6_cnt", {24'd0, err_cnt_b}, 32'd1);
    sel_b = 3'd2;
    step();
    chk("bin2_data", {22'd0, out_data_b}, 32'h013);
    in_valid_b = 1'b0;
    step();

    // asynchronous reset while holding valid data
    in_valid_l = 1'b1; sel_l = 2'b10;
    step();
    in_valid_l = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid_l}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid_l}, 32'd0);
    chk("arst_data", {22'd0, out_data_l}, 32'd0);
    chk("arst_cnt", {24'd0, err_cnt_l}, 32'd0);
    chk("arst_err", {31'd0, sel_err_l}, 32'd0);
    #1;
    reset = 1'b0;
    in_valid_l = 1'b1; sel_l = 2'b01;
    step();
    chk("post_rst_data", {22'd0, out_data_l}, 32'h003);
    chk("post_rst_valid", {31'd0, out_valid_l}, 32'd1);
    in_valid_l = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fwd_mux_pipe.md
Name: fwd_mux_pipe

Overview:
- Parametrised N-way operand-forwarding multiplexer with a registered output stage. Successor to the combinational 3-to-1 bus mux used on the EX-stage operand paths.
- Adds valid/ready flow control, stall and flush, illegal-select detection, and a saturating error counter.
- Sits between the forwarding unit and the ALU operand register in the MIPS-DLX pipeline.

Parameters:
- BUS_SIZE, 10, data width of each input and of the output.
- NUM_IN, 3, number of data inputs; legal range 2..8.
- LEGACY_ENC, 1, 1 selects the legacy 2-bit encoding (00->in0, 10->in1, 01->in2, 11->illegal) and requires NUM_IN=3. 0 selects a binary index.
- ERR_CNT_W, 8, width of the illegal-select counter.
- Localparam SEL_W = max(1, clog2(NUM_IN)); forced to 2 when LEGACY_ENC=1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_bus  in  NUM_IN*BUS_SIZE  packed inputs; input k occupies bits [k*BUS_SIZE +: BUS_SIZE].
- sel  in  SEL_W  source select, sampled on an accepted transfer.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  discard the held result (branch mispredict / exception).
- out_data  out  BUS_SIZE  registered selected operand.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts this cycle.
- sel_err  out  1  sticky flag: an illegal select was accepted.
- err_cnt  out  ERR_CNT_W  saturating count of accepted illegal selects.

Behaviour:
- Reset (async, immediate): out_data=0, out_valid=0, sel_err=0, err_cnt=0. in_ready is combinational and equals 1 while reset is deasserted and the stage is empty.
- in_ready = !out_valid || out_ready (single-entry pipeline register). It is a pure function of state and out_ready; it does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, at the next edge: out_data <= selected input, out_valid <= 1. Latency is 1 cycle from accept to out_valid.
- Drain: if out_valid && out_ready && !accept, then out_valid <= 0 and out_data holds its last value.
- Simultaneous drain and accept: the register is replaced with no bubble, and out_valid stays 1.
- Stall: if out_valid && !out_ready, out_data and out_valid hold and in_ready=0.
- flush has priority over everything:
  - At the edge, out_valid <= 0 and any concurrent accept is dropped.
  - in_ready is still driven per the formula (so an in_valid during flush is consumed and lost).
  - sel_err and err_cnt are not updated for a flushed accept.
- Select decode:
  - LEGACY_ENC=1: 00->in0, 10->in1, 01->in2, 11->illegal.
  - LEGACY_ENC=0: index sel; sel >= NUM_IN is illegal.
- Illegal select on an accept (no flush):
  - out_data <= in0 (legacy default) and out_valid <= 1.
  - sel_err <= 1 (cleared only by reset).
  - err_cnt increments and saturates at all-ones.
- sel and in_bus are only observed on accept cycles; their values outside accept cycles have no effect.
- Reset asserted mid-transfer clears the held data immediately. No output glitches on deassertion, because outputs come directly from flops.

Decomposition:
- Shared package fwd_pkg:
  - Legacy select constants FWD_SEL_A=2'b00, FWD_SEL_B=2'b10, FWD_SEL_C=2'b01.
  - Function clog2.
- Natural sub-module fwd_sel_decode (combinational): sel -> one-hot source plus an illegal flag, parametrised by NUM_IN and LEGACY_ENC. The top level holds the register, handshake and counter.

Test Plan:
- Legacy, in0=0x001, in1=0x002, in2=0x003; sel=00,10,01 on consecutive accepts with out_ready=1 -> out_data 0x001,0x002,0x003 one cycle after each accept, out_valid continuous.
- sel=11 accepted -> out_data=0x001, sel_err=1, err_cnt=1. Repeat 300 times with ERR_CNT_W=8 -> err_cnt saturates at 255.
- Accept 0x002 then hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stays 0x002. Release -> next value appears the following cycle with no bubble.
- flush asserted in the same cycle as an accept with sel=11 -> out_valid=0 next cycle, err_cnt and sel_err unchanged.
- LEGACY_ENC=0, NUM_IN=5, sel=4 -> in4 forwarded. sel=6 -> in0 forwarded, sel_err=1.
- Assert reset asynchronously mid-cycle while out_valid=1 -> out_valid, out_data, err_cnt go to 0 without waiting for clk. After release, the first accept works normally.
